led_pattern_sequencer: RTL

Playback controller and arbiter for a 16 x 6 LED pattern RAM. It steps through a programmable address window at a fixed tick rate and drives the board LEDs from the fetched words. It also shares the single RAM port with a host write requester, so patterns can be reloaded while playback runs. It sits between the top-level LED pins and whatever loader, such as a UART or button logic, owns the write port.

---
 rtl/led_pattern_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/led_pattern_sequencer.sv
// Pattern RAM playback controller: steps a 16x6 RAM window at a fixed tick rate onto the LEDs,
// sharing the single RAM port with a host writer. Define PINGPONG_EN for bounce-mode addressing.
module led_pattern_sequencer #(
  parameter int WAIT_TIME  = 27000000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_req,
  input  logic [3:0] wr_addr,
  input  logic [5:0] wr_data,
  output logic       wr_ack,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] first_addr,
  input  logic [3:0] last_addr,
  output logic       busy,
  output logic [3:0] step_addr,
  output logic       wrap,
  output logic [5:0] leds
);

  localparam int CW = (WAIT_TIME > 1) ? $clog2(WAIT_TIME) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_TIME - 1);
  localparam logic [5:0] LED_OFF = (ACTIVE_LOW != 0) ? 6'h3F : 6'h00;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FETCH, S_SHOW} state_t;

  // Power-up contents; rst deliberately leaves the RAM alone.
  logic [5:0] mem [16] = '{6'b000001, 6'b000010, 6'b000100, 6'b001000,
                           6'b010000, 6'b100000, 6'b100000, 6'b010000,
                           6'b001000, 6'b000100, 6'b000010, 6'b000001,
                           6'b000000, 6'b000000, 6'b000000, 6'b000000};

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    ptr;
  logic [3:0]    first_q;
  logic [3:0]    last_q;
  logic [5:0]    rd_data;
  logic          wr_last;
  logic          grant;
`ifdef PINGPONG_EN
  logic          dir_down;
`endif

  // A write loses FETCH only when it also won the previous cycle, so neither side starves.
  assign grant = wr_req && !(state == S_FETCH && wr_last);

  always_ff @(posedge clk) begin
    if (grant && !rst) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ptr       <= 4'd0;
      first_q   <= 4'd0;
      last_q    <= 4'd0;
      rd_data   <= 6'd0;
      wr_last   <= 1'b0;
      wr_ack    <= 1'b0;
      wrap      <= 1'b0;
      busy      <= 1'b0;
      leds      <= LED_OFF;
      step_addr <= 4'd0;
`ifdef PINGPONG_EN
      dir_down  <= 1'b0;
`endif
    end else begin
      wr_last <= grant;
      wr_ack  <= grant;
      wrap    <= 1'b0;
      if (stop) begin
        state <= S_IDLE;
        busy  <= 1'b0;
        leds  <= LED_OFF;
        cnt   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              first_q <= first_addr;
              last_q  <= (last_addr < first_addr) ? first_addr : last_addr;
              ptr     <= first_addr;
`ifdef PINGPONG_EN
              dir_down <= 1'b0;
`endif
              busy    <= 1'b1;
              state   <= S_FETCH;
            end
          end
          S_WAIT: begin
            if (cnt == CNT_LAST) state <= S_FETCH;
            else cnt <= cnt + 1'b1;
          end
          S_FETCH: begin
            if (!grant) begin
              rd_data <= mem[ptr];
              state   <= S_SHOW;
            end
          end
          S_SHOW: begin
            leds      <= (ACTIVE_LOW != 0) ? ~rd_data : rd_data;
            step_addr <= ptr;
            cnt       <= '0;
            state     <= S_WAIT;
`ifdef PINGPONG_EN
            if (first_q == last_q) begin
              wrap <= 1'b1;
            end else if (!dir_down) begin
              if (ptr == last_q) begin
                dir_down <= 1'b1;
                ptr      <= ptr - 4'd1;
                wrap     <= 1'b1;
              end else begin
                ptr <= ptr + 4'd1;
              end
            end else begin
              if (ptr == first_q) begin
                dir_down <= 1'b0;
                ptr      <= ptr + 4'd1;
                wrap     <= 1'b1;
              end else begin
                ptr <= ptr - 4'd1;
              end
            end
`else
            if (ptr == last_q) begin
              ptr  <= first_q;
              wrap <= 1'b1;
            end else begin
              ptr <= ptr + 4'd1;
            end
`endif
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
